// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: sequencer states,
// decoder writeback-select values and the reset instruction.
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  localparam logic [1:0]  INPUT_REG_MEM = 2'b10;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

  // Loads and stores are the only instructions that visit the data memory.
  function automatic logic needs_mem(input logic mem_we, input logic [1:0] input_reg);
    return mem_we || (input_reg == INPUT_REG_MEM);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Signal bundle between the sequencer and the memories, decoder, register
// file and PC register.
interface multicycle_control_fsm_if;
  // Handshake: a request (imem_req / dmem_req) stays high until the cycle in
  // which the matching ready is seen; the transfer completes on req && ready
  // in that same cycle. Ready while no request is pending is ignored.
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic        dec_we_reg;
  logic        dec_mem_we;
  logic [1:0]  dec_input_reg;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;
  logic        reg_we;
  logic        pc_we;
  logic [31:0] instret;
  logic        trap;
  logic [2:0]  state;

  modport master (
    input  imem_req, ir, dmem_req, dmem_we, reg_we, pc_we, instret, trap, state,
    output imem_ready, imem_rdata, dec_we_reg, dec_mem_we, dec_input_reg, dmem_ready
  );

  modport slave (
    output imem_req, ir, dmem_req, dmem_we, reg_we, pc_we, instret, trap, state,
    input  imem_ready, imem_rdata, dec_we_reg, dec_mem_we, dec_input_reg, dmem_ready
  );
endinterface

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// Counts cycles a memory request has waited for ready and flags the cycle in
// which the wait limit is reached without ready.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic ready,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (enable && !ready) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Ready in the limit cycle still completes the access.
  assign timeout = (MEM_TIMEOUT != 0) && enable && !ready && (r_cnt == LIMIT);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencer: fetches into IR, steps DECODE/EXEC/MEM/WB and
// gates decoder write enables so each side effect fires once per instruction.
module multicycle_control_fsm
  import core_ctrl_pkg::*;
#(
  parameter int          MEM_TIMEOUT = 16,
  parameter int          CNT_W       = 8,
  parameter logic [31:0] RESET_IR    = NOP_INSTR
) (
  input logic                     clk,
  input logic                     reset,
  multicycle_control_fsm_if.slave bus
);

  state_e      r_state;
  state_e      w_next;
  logic [31:0] r_ir;
  logic [31:0] r_instret;
  logic        w_wait_en;
  logic        w_wait_ready;
  logic        w_timeout;

  assign w_wait_en    = (r_state == ST_FETCH) || (r_state == ST_MEM);
  assign w_wait_ready = (r_state == ST_FETCH) ? bus.imem_ready : bus.dmem_ready;

  // Held clear outside FETCH/MEM, so every entry into either starts from zero.
  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_wait (
    .clk     (clk),
    .reset   (reset),
    .clear   (!w_wait_en),
    .enable  (w_wait_en),
    .ready   (w_wait_ready),
    .timeout (w_timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_START;
      r_ir      <= RESET_IR;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_FETCH && bus.imem_ready) begin
        r_ir <= bus.imem_rdata;
      end
      if (r_state == ST_WB) begin
        r_instret <= r_instret + 32'd1;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    bus.reg_we   = 1'b0;
    bus.pc_we    = 1'b0;
    bus.trap     = 1'b0;
    case (r_state)
      ST_START:  w_next = ST_FETCH;
      ST_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ready)  w_next = ST_DECODE;
        else if (w_timeout)  w_next = ST_TRAP;
      end
      ST_DECODE: w_next = ST_EXEC;
      ST_EXEC:   w_next = needs_mem(bus.dec_mem_we, bus.dec_input_reg) ? ST_MEM : ST_WB;
      ST_MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = bus.dec_mem_we;
        if (bus.dmem_ready)  w_next = ST_WB;
        else if (w_timeout)  w_next = ST_TRAP;
      end
      ST_WB: begin
        bus.reg_we = bus.dec_we_reg;
        bus.pc_we  = 1'b1;
        w_next     = ST_FETCH;
      end
      ST_TRAP: begin
        bus.trap = 1'b1;
        w_next   = ST_TRAP;
      end
      default:   w_next = ST_START;
    endcase
  end

  assign bus.ir      = r_ir;
  assign bus.instret = r_instret;
  assign bus.state   = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: builds a per-cycle table of inputs and
// expected outputs from instruction-level rules, then replays it on the DUT.
module tb_multicycle_control_fsm;

  localparam int          TMO = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;

  multicycle_control_fsm_if bus();

  multicycle_control_fsm #(
    .MEM_TIMEOUT (TMO),
    .CNT_W       (8),
    .RESET_IR    (NOP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // e_ctrl = {state[2:0], imem_req, dmem_req, dmem_we, reg_we, pc_we, trap}
  typedef struct {
    logic        rst;
    logic        chk;
    logic        frc;
    logic [31:0] frc_val;
    logic        i_rdy;
    logic [31:0] i_data;
    logic        we_reg;
    logic        mem_we;
    logic [1:0]  in_reg;
    logic        d_rdy;
    logic [8:0]  e_ctrl;
    logic [31:0] e_ir;
    logic [31:0] e_instret;
  } vec_t;

  vec_t        vq[$];
  logic [31:0] m_ir;
  logic [31:0] m_instret;
  logic        pend_frc;
  logic [31:0] pend_val;
  logic        cur_we;
  logic        cur_mwe;
  logic [1:0]  cur_inreg;
  logic [31:0] frc_v;
  int          n_tests;
  int          n_fail;

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic logic [31:0] rw();
    return $urandom;
  endfunction

  task automatic push(input logic rst, input logic chk, input logic i_rdy,
                      input logic [31:0] i_data, input logic d_rdy,
                      input logic [2:0] st, input logic [5:0] en);
    vec_t v;
    v.rst = rst;  v.chk = chk;
    v.frc = pend_frc;  v.frc_val = pend_val;  pend_frc = 1'b0;
    v.i_rdy = i_rdy;  v.i_data = i_data;  v.d_rdy = d_rdy;
    v.we_reg = cur_we;  v.mem_we = cur_mwe;  v.in_reg = cur_inreg;
    v.e_ctrl = {st, en};  v.e_ir = m_ir;  v.e_instret = m_instret;
    vq.push_back(v);
  endtask

  task automatic gen_reset_start();
    push(1'b1, 1'b0, rb(), rw(), rb(), 3'd0, 6'b0);
    push(1'b1, 1'b0, rb(), rw(), rb(), 3'd0, 6'b0);
    m_ir = NOP;
    m_instret = 32'd0;
    push(1'b0, 1'b1, rb(), rw(), rb(), 3'd0, 6'b0);
  endtask

  task automatic gen_trap(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b1, rb(), rw(), rb(), 3'd6, 6'b000001);
  endtask

  task automatic gen_fetch(input int fw, input logic [31:0] data);
    for (int i = 0; i < fw; i++) push(1'b0, 1'b1, 1'b0, rw(), rb(), 3'd1, 6'b100000);
    push(1'b0, 1'b1, 1'b1, data, rb(), 3'd1, 6'b100000);
    m_ir = data;
  endtask

  // kind: 0 alu, 1 branch, 2 load, 3 store. mw >= TMO means data memory never answers.
  task automatic gen_instr(input int kind, input int fw, input int mw, input logic [31:0] data);
    logic [1:0] t;
    logic       is_mem;
    t = 2'($urandom_range(2, 0));
    if (t == 2'b10) t = 2'b11;
    case (kind)
      0:       begin cur_we = 1'b1; cur_mwe = 1'b0; cur_inreg = t;     end
      1:       begin cur_we = 1'b0; cur_mwe = 1'b0; cur_inreg = t;     end
      2:       begin cur_we = 1'b1; cur_mwe = 1'b0; cur_inreg = 2'b10; end
      default: begin cur_we = 1'b0; cur_mwe = 1'b1; cur_inreg = 2'($urandom_range(3, 0)); end
    endcase
    is_mem = (kind >= 2);
    gen_fetch(fw, data);
    push(1'b0, 1'b1, rb(), rw(), rb(), 3'd2, 6'b0);
    push(1'b0, 1'b1, rb(), rw(), rb(), 3'd3, 6'b0);
    if (is_mem) begin
      for (int i = 0; i < mw && i < TMO; i++)
        push(1'b0, 1'b1, rb(), rw(), 1'b0, 3'd4, {2'b01, cur_mwe, 3'b000});
      if (mw >= TMO) begin
        gen_trap(4);
        return;
      end
      push(1'b0, 1'b1, rb(), rw(), 1'b1, 3'd4, {2'b01, cur_mwe, 3'b000});
    end
    push(1'b0, 1'b1, rb(), rw(), rb(), 3'd5, {3'b000, cur_we, 2'b10});
    m_instret = m_instret + 32'd1;
  endtask

  task automatic build_schedule();
    pend_frc = 1'b0;  pend_val = '0;
    cur_we = 1'b0;  cur_mwe = 1'b0;  cur_inreg = 2'b00;
    m_ir = NOP;  m_instret = '0;

    // Directed: addi, lw with 3 waits, sw, branch, slow fetch, ready on last allowed cycle.
    gen_reset_start();
    gen_instr(0, 0, 0, 32'h0010_0093);
    gen_instr(2, 0, 3, 32'h0000_a103);
    gen_instr(3, 0, 0, 32'h0020_a223);
    gen_instr(1, 0, 0, 32'h0000_0463);
    gen_instr(0, 2, 0, 32'h0030_0193);
    gen_instr(0, TMO - 1, 0, 32'h0040_0213);
    gen_instr(2, 1, TMO - 1, 32'h0041_2283);

    // Randomized instruction mix with short memory waits.
    for (int n = 0; n < 40; n++)
      gen_instr(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                int'($urandom_range(4, 0)), rw());

    // instret wraps from all-ones to zero.
    pend_frc = 1'b1;
    pend_val = 32'hFFFF_FFFE;
    m_instret = pend_val;
    gen_instr(0, 0, 0, rw());
    gen_instr(2, 0, 1, rw());
    gen_instr(1, 0, 0, rw());

    // Data memory never answers: TRAP, then recovery by reset.
    gen_instr(2, 0, TMO, rw());
    gen_reset_start();

    // Reset during a MEM wait: no writeback, requests drop, IR restored.
    cur_we = 1'b1;  cur_mwe = 1'b0;  cur_inreg = 2'b10;
    gen_fetch(0, 32'h0000_2303);
    push(1'b0, 1'b1, rb(), rw(), rb(), 3'd2, 6'b0);
    push(1'b0, 1'b1, rb(), rw(), rb(), 3'd3, 6'b0);
    push(1'b0, 1'b1, rb(), rw(), 1'b0, 3'd4, 6'b010000);
    push(1'b0, 1'b1, rb(), rw(), 1'b0, 3'd4, 6'b010000);
    push(1'b1, 1'b1, rb(), rw(), 1'b0, 3'd4, 6'b010000);
    m_ir = NOP;
    m_instret = '0;
    push(1'b0, 1'b1, rb(), rw(), rb(), 3'd0, 6'b0);
    gen_instr(3, 0, 0, rw());

    // Instruction memory never answers: TRAP after TMO fetch cycles.
    cur_we = 1'b1;  cur_mwe = 1'b0;  cur_inreg = 2'b00;
    for (int i = 0; i < TMO; i++) push(1'b0, 1'b1, 1'b0, rw(), rb(), 3'd1, 6'b100000);
    gen_trap(6);
  endtask

  task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    bus.imem_ready = 1'b0;  bus.imem_rdata = '0;
    bus.dec_we_reg = 1'b0;  bus.dec_mem_we = 1'b0;  bus.dec_input_reg = 2'b00;
    bus.dmem_ready = 1'b0;
    build_schedule();

    for (int k = 0; k < vq.size(); k++) begin
      @(negedge clk);
      reset              = vq[k].rst;
      bus.imem_ready     = vq[k].i_rdy;
      bus.imem_rdata     = vq[k].i_data;
      bus.dec_we_reg     = vq[k].we_reg;
      bus.dec_mem_we     = vq[k].mem_we;
      bus.dec_input_reg  = vq[k].in_reg;
      bus.dmem_ready     = vq[k].d_rdy;
      if (vq[k].frc) begin
        frc_v = vq[k].frc_val;
        force dut.r_instret = frc_v;
        #1;
        release dut.r_instret;
      end
      #1;
      if (vq[k].chk) begin
        check("ctrl", k, {23'd0, bus.state, bus.imem_req, bus.dmem_req, bus.dmem_we,
                          bus.reg_we, bus.pc_we, bus.trap}, {23'd0, vq[k].e_ctrl});
        check("ir", k, bus.ir, vq[k].e_ir);
        check("instret", k, bus.instret, vq[k].e_instret);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multi-cycle sequencer for the RV32I core. It fetches an instruction into the instruction register (IR) that drives the decoder. It then steps the datapath through DECODE/EXEC/MEM/WB and gates the decoder's write enables so that each architectural side effect fires exactly once per instruction. It sits between the instruction/data memory handshakes and the decoder, register file and PC register.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory request may wait for ready before TRAP; 0 disables the timeout
CNT_W, 8, width of the wait counter; MEM_TIMEOUT must be < 2**CNT_W
RESET_IR, 32'h00000013, IR value after reset (addi x0,x0,0)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
imem_req  out  1  instruction fetch request
imem_ready  in  1  fetch data valid this cycle
imem_rdata  in  32  fetched instruction
ir  out  32  instruction register, feeds decoder instruction input
dec_we_reg  in  1  decoder register-write enable
dec_mem_we  in  1  decoder store flag
dec_input_reg  in  2  decoder writeback select; 2'b10 = load
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (store)
dmem_ready  in  1  data access complete this cycle
reg_we  out  1  gated register-file write enable
pc_we  out  1  PC register update enable
instret  out  32  retired instruction count
trap  out  1  sticky memory-timeout flag
state  out  3  current state, for debug/bench

Behaviour:
- Clock and reset: one clock clk; reset is synchronous, active-high, sampled on the rising clk edge.
- Reset effects:
  - state <= START, ir <= RESET_IR, instret <= 0, wait counter <= 0, trap <= 0.
  - All outputs are Moore-decoded from state, so in START every request/enable output is 0.
- States: START=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6; 7 is unreachable and recovers to START.
- START: all outputs 0; next state FETCH unconditionally.
- FETCH:
  - imem_req=1.
  - imem_ready=1 in the same cycle as req is accepted: ir <= imem_rdata, go to DECODE.
  - Otherwise the wait counter increments.
- DECODE: one cycle so the decoder output settles from the new ir; go to EXEC.
- EXEC: one cycle for the ALU.
  - Go to MEM if dec_mem_we=1 or dec_input_reg==2'b10.
  - Otherwise go to WB.
- MEM:
  - dmem_req=1, dmem_we=dec_mem_we.
  - dmem_ready=1 goes to WB; otherwise the wait counter increments.
- WB:
  - reg_we=dec_we_reg and pc_we=1, each for exactly one cycle.
  - instret <= instret+1, wrapping at 2**32.
  - Go to FETCH.
- reg_we, pc_we, dmem_req, dmem_we and imem_req are 0 in every state not listed above.
- Wait counter:
  - Cleared on every entry into FETCH or MEM.
  - If MEM_TIMEOUT != 0, the counter equals MEM_TIMEOUT-1 and ready is 0, go to TRAP.
  - Ready arriving in that same cycle wins over the timeout.
- TRAP: trap=1, all other enables 0, ir/instret frozen; only reset leaves it.
- Latency with zero-wait memories:
  - ALU/branch/jump instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load or store: 5 cycles.
  - Each memory wait cycle adds 1.
- Stores: pass through WB with reg_we=0, because the decoder drives we_reg=0 for stores.
- Reset asserted mid-instruction (any state, including MEM with dmem_req high): next cycle is START, request outputs drop to 0, and no partial writeback occurs.
- ir changes only on the FETCH handshake cycle; the decoder inputs are stable through DECODE..WB.

Decomposition:
- Shared package core_ctrl_pkg holds:
  - state encoding constants (START..TRAP);
  - INPUT_REG_MEM = 2'b10;
  - NOP_INSTR = 32'h00000013.
  The decoder and datapath use the same encodings.
- One sub-module, mem_wait_timer: clear, enable, ready, parameter MEM_TIMEOUT/CNT_W; outputs timeout.

Test Plan:
- Reset, then addi with imem_ready tied 1 -> state START,FETCH,DECODE,EXEC,WB; reg_we=1 only in WB; pc_we one pulse; instret=1 after 5 cycles from reset release.
- lw (input_reg=2'b10, we_reg=1) with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, reg_we pulse in WB, 8 cycles FETCH-to-FETCH.
- sw (mem_we=1, we_reg=0) -> dmem_req=dmem_we=1 in MEM; reg_we stays 0; pc_we pulses once.
- imem_ready held 0, MEM_TIMEOUT=16 -> TRAP entered on cycle 16 of FETCH, trap=1 sticky, imem_req=0; ready on cycle 16 instead -> DECODE, no trap.
- reset asserted during MEM wait -> next cycle state=START, dmem_req=0, instret unchanged, ir=32'h00000013.
- Preload instret near 2**32 (force) or run 2**32 retirements -> instret wraps 32'hFFFFFFFF to 0 with no other effect.
